// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers (write and read side).
//
// Contents:
//   DEFAULT_ADDRSIZE / DEPTH : default FIFO geometry (depth = 2^ADDRSIZE).
//   bin2gray / gray2bin      : width-generic Gray conversions. They operate on a
//                              32-bit container; callers zero-extend a narrower
//                              pointer in and slice the result back out. Leading
//                              zeros do not disturb either conversion.
package afifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 4;
  localparam int DEPTH            = 1 << DEFAULT_ADDRSIZE;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus between the producer / pointer synchronizer and wptr_full_ctrl.
//
// Signals:
//   winc         producer write request
//   wq2_rptr     Gray read pointer, already synchronized to wclk
//   waddr        RAM write address
//   wptr         Gray write pointer to the read-domain synchronizer
//   wfull        full flag
//   walmost_full fill level >= threshold
//   wlevel       fill level seen from the write side
//   wovf         sticky overflow       (only with WPTR_FULL_OVF_EN)
//   wdrop_cnt    saturating drop count (only with WPTR_FULL_OVF_EN)
//
// Modports: master = producer side, slave = wptr_full_ctrl.
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
`ifdef WPTR_FULL_OVF_EN
  logic                wovf;
  logic [7:0]          wdrop_cnt;

  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );
  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );
`else
  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel
  );
  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wlevel
  );
`endif
endinterface

// File: rtl/wptr_full_ctrl_gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter (XOR prefix from the MSB).
// Used for the synchronized read pointer here and for the write pointer on the
// read side.
//
// Ports:
//   i_gray  W-bit Gray code in
//   o_bin   W-bit binary out
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer and full-flag controller of the async FIFO.
// Holds the binary write counter, drives the RAM write address and the Gray write
// pointer, and compares against the synchronized read pointer to produce full,
// almost-full and fill level. All outputs are registered; winc has no
// combinational path to any output.
//
// Ports:
//   wclk    write clock
//   wrst_n  synchronous active-low reset (priority over winc)
//   bus     wptr_full_ctrl_if.slave (winc, wq2_rptr in; waddr, wptr, wfull,
//           walmost_full, wlevel out; wovf, wdrop_cnt out with the macro)
//
// Build option: define WPTR_FULL_OVF_EN to add the sticky overflow flag and the
// saturating dropped-write counter.
module wptr_full_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic             wclk,
  input  logic             wrst_n,
  wptr_full_ctrl_if.slave  bus
);

  localparam int A = ADDRSIZE;

  logic [A:0] r_wbin;
  logic [A:0] r_wptr;
  logic [A:0] r_wlevel;
  logic       r_wfull;
  logic       r_walmost_full;

  logic       w_wacc;
  logic [A:0] w_wbin_next;
  logic [A:0] w_wgray_next;
  logic [A:0] w_rbin;
  logic [A:0] w_rptr_full_pat;
  logic [A:0] w_wlevel_next;
  logic       w_wfull_next;
  logic       w_walmost_full_next;

  gray2bin_conv #(.W(A + 1)) u_rptr_conv (
    .i_gray (bus.wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Next-state: accept only when not full; wbin wraps naturally modulo 2^(A+1).
  assign w_wacc       = bus.winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{A{1'b0}}, w_wacc};
  assign w_wgray_next = (A + 1)'(bin2gray(32'(w_wbin_next)));

  // Full when write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign w_rptr_full_pat     = {~bus.wq2_rptr[A:A-1], bus.wq2_rptr[A-2:0]};
  assign w_wfull_next        = (w_wgray_next == w_rptr_full_pat);
  assign w_wlevel_next       = w_wbin_next - w_rbin;
  assign w_walmost_full_next = (32'(w_wlevel_next) >= 32'(AFULL_THRESH));

  // ---- register stage: pointer and flag state ----
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wlevel       <= w_wlevel_next;
      r_wfull        <= w_wfull_next;
      r_walmost_full <= w_walmost_full_next;
    end
  end

  assign bus.waddr        = r_wbin[A-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;

`ifdef WPTR_FULL_OVF_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       r_wovf;
  logic [7:0] r_wdrop_cnt;

  // ---- register stage: overflow tracking (write attempted while full) ----
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wovf      <= 1'b0;
      r_wdrop_cnt <= '0;
    end else if (bus.winc & r_wfull) begin
      r_wovf      <= 1'b1;
      r_wdrop_cnt <= sat_inc8(r_wdrop_cnt);
    end
  end

  assign bus.wovf      = r_wovf;
  assign bus.wdrop_cnt = r_wdrop_cnt;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDRSIZE=4, AFULL_THRESH=12).
// The reference model counts total accepted writes and total reads as plain
// integers; level, address, Gray pointer and flags are derived from those counts.
module tb_wptr_full_ctrl;

  logic wclk;
  logic wrst_n;

  wptr_full_ctrl_if #(.ADDRSIZE(4)) bus ();

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_vec;
  int n_err;

  // Reference model state
  int m_wcnt;   // total accepted writes since reset
  int m_rd;     // total reads presented on wq2_rptr
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;
  int m_drop;

  function automatic logic [4:0] gray5(input int n);
    int m;
    m = n % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  // One clock: drive inputs on the falling edge, advance the model at the rising
  // edge, return 1 time unit later so outputs are settled.
  task automatic tick(input bit rst_n_i, input bit winc_i, input int rcnt_i);
    @(negedge wclk);
    wrst_n       = rst_n_i;
    bus.winc     = winc_i;
    bus.wq2_rptr = gray5(rcnt_i);
    @(posedge wclk);
    if (!rst_n_i) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (winc_i && m_full) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (winc_i && !m_full) m_wcnt++;
      m_level = m_wcnt - rcnt_i;
      m_full  = (m_level == 16);
      m_afull = (m_level >= 12);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 0);
    n_vec++; if (bus.wptr !== 5'd0) begin n_err++; $display("FAIL reset_wptr got=%0h exp=0", bus.wptr); end
    n_vec++; if (bus.waddr !== 4'd0) begin n_err++; $display("FAIL reset_waddr got=%0h exp=0", bus.waddr); end
    n_vec++; if (bus.wlevel !== 5'd0) begin n_err++; $display("FAIL reset_wlevel got=%0d exp=0", bus.wlevel); end
    n_vec++; if (bus.wfull !== 1'b0) begin n_err++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
    n_vec++; if (bus.walmost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got=%b exp=0", bus.walmost_full); end
`ifdef WPTR_FULL_OVF_EN
    n_vec++; if (bus.wovf !== 1'b0 || bus.wdrop_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_ovf got=%b/%0d exp=0/0", bus.wovf, bus.wdrop_cnt); end
`endif
    m_rd = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (bus.waddr !== 4'(i)) begin n_err++; $display("FAIL fill_waddr got=%0d exp=%0d", bus.waddr, i); end
      tick(1'b1, 1'b1, 0);
      n_vec++; if (bus.wlevel !== 5'(i + 1)) begin n_err++; $display("FAIL fill_wlevel got=%0d exp=%0d", bus.wlevel, i + 1); end
      n_vec++; if (bus.walmost_full !== (i + 1 >= 12)) begin
        n_err++; $display("FAIL fill_afull got=%b exp=%b lvl=%0d", bus.walmost_full, (i + 1 >= 12), i + 1); end
      n_vec++; if (bus.wfull !== (i == 15)) begin n_err++; $display("FAIL fill_wfull got=%b exp=%b", bus.wfull, (i == 15)); end
    end
    n_vec++; if (bus.wptr !== 5'b11000) begin n_err++; $display("FAIL fill_wptr got=%b exp=11000", bus.wptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 0);
      n_vec++; if (bus.wptr !== 5'b11000) begin n_err++; $display("FAIL ovf_wptr got=%b exp=11000", bus.wptr); end
      n_vec++; if (bus.waddr !== 4'd0) begin n_err++; $display("FAIL ovf_waddr got=%0d exp=0", bus.waddr); end
      n_vec++; if (bus.wfull !== 1'b1) begin n_err++; $display("FAIL ovf_wfull got=%b exp=1", bus.wfull); end
    end
`ifdef WPTR_FULL_OVF_EN
    n_vec++; if (bus.wovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", bus.wovf); end
    n_vec++; if (bus.wdrop_cnt !== 8'd3) begin n_err++; $display("FAIL ovf_dropcnt got=%0d exp=3", bus.wdrop_cnt); end
`endif
  endtask

  task automatic test_drain();
    m_rd = 1;
    tick(1'b1, 1'b0, m_rd);
    n_vec++; if (bus.wfull !== 1'b0) begin n_err++; $display("FAIL drain_wfull got=%b exp=0", bus.wfull); end
    n_vec++; if (bus.wlevel !== 5'd15) begin n_err++; $display("FAIL drain_lvl15 got=%0d exp=15", bus.wlevel); end
    m_rd = 5;
    tick(1'b1, 1'b0, m_rd);
    n_vec++; if (bus.wlevel !== 5'd11) begin n_err++; $display("FAIL drain_lvl11 got=%0d exp=11", bus.wlevel); end
    n_vec++; if (bus.walmost_full !== 1'b0) begin n_err++; $display("FAIL drain_afull got=%b exp=0", bus.walmost_full); end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    for (int i = 0; i < 40; i++) begin
      prev = bus.wptr;
      m_rd = m_wcnt - 2;
      tick(1'b1, 1'b1, m_rd);
      n_vec++; if ($countones(prev ^ bus.wptr) != 1) begin
        n_err++; $display("FAIL wrap_onebit prev=%b now=%b exp one bit change", prev, bus.wptr); end
      n_vec++; if (bus.wptr !== gray5(m_wcnt)) begin n_err++; $display("FAIL wrap_wptr got=%b exp=%b", bus.wptr, gray5(m_wcnt)); end
      n_vec++; if (bus.waddr !== 4'(m_wcnt % 16)) begin n_err++; $display("FAIL wrap_waddr got=%0d exp=%0d", bus.waddr, m_wcnt % 16); end
      n_vec++; if (bus.wfull !== 1'b0) begin n_err++; $display("FAIL wrap_wfull got=%b exp=0", bus.wfull); end
      n_vec++; if (bus.wlevel !== 5'd3) begin n_err++; $display("FAIL wrap_wlevel got=%0d exp=3", bus.wlevel); end
    end
  endtask

  task automatic test_random();
    logic [4:0] prev;
    bit         w;
    for (int i = 0; i < 400; i++) begin
      prev = bus.wptr;
      w = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) m_rd = m_rd + $urandom_range(0, m_wcnt - m_rd);
      tick(1'b1, w, m_rd);
      n_vec++; if ($countones(prev ^ bus.wptr) > 1) begin
        n_err++; $display("FAIL rand_onebit prev=%b now=%b", prev, bus.wptr); end
      n_vec++; if (bus.wptr !== gray5(m_wcnt) || bus.waddr !== 4'(m_wcnt % 16)) begin
        n_err++; $display("FAIL rand_ptr got=%b/%0d exp=%b/%0d", bus.wptr, bus.waddr, gray5(m_wcnt), m_wcnt % 16); end
      n_vec++; if (bus.wlevel !== 5'(m_level) || bus.wfull !== m_full || bus.walmost_full !== m_afull) begin
        n_err++; $display("FAIL rand_flags got=%0d/%b/%b exp=%0d/%b/%b",
                          bus.wlevel, bus.wfull, bus.walmost_full, m_level, m_full, m_afull); end
`ifdef WPTR_FULL_OVF_EN
      n_vec++; if (bus.wovf !== m_ovf || bus.wdrop_cnt !== 8'(m_drop)) begin
        n_err++; $display("FAIL rand_ovf got=%b/%0d exp=%b/%0d", bus.wovf, bus.wdrop_cnt, m_ovf, m_drop); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    m_rd = m_wcnt;
    tick(1'b1, 1'b0, m_rd);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, m_rd);
    n_vec++; if (bus.wlevel !== 5'd9) begin n_err++; $display("FAIL mid_pre_level got=%0d exp=9", bus.wlevel); end
    tick(1'b0, 1'b1, m_rd);
    n_vec++; if (bus.wptr !== 5'd0 || bus.waddr !== 4'd0) begin
      n_err++; $display("FAIL mid_ptr got=%b/%0d exp=0/0", bus.wptr, bus.waddr); end
    n_vec++; if (bus.wlevel !== 5'd0 || bus.wfull !== 1'b0 || bus.walmost_full !== 1'b0) begin
      n_err++; $display("FAIL mid_flags got=%0d/%b/%b exp=0/0/0", bus.wlevel, bus.wfull, bus.walmost_full); end
`ifdef WPTR_FULL_OVF_EN
    n_vec++; if (bus.wovf !== 1'b0 || bus.wdrop_cnt !== 8'd0) begin
      n_err++; $display("FAIL mid_ovf got=%b/%0d exp=0/0", bus.wovf, bus.wdrop_cnt); end
`endif
    m_rd = 0;
    tick(1'b1, 1'b0, m_rd);
    n_vec++; if (bus.wptr !== 5'd0 || bus.wlevel !== 5'd0) begin
      n_err++; $display("FAIL mid_after got=%b/%0d exp=0/0", bus.wptr, bus.wlevel); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_wcnt = 0; m_rd = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_drop = 0;
    wrst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wq2_rptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
